// File: rtl/vga_multi_window_painter_if.sv
// Painter bus: timing-controller inputs, memory read port and RGB/sync outputs.
//   slave  : painter side (consumes X/Y/syncs/controls/rd_data, drives rd_addr/RGB/syncs)
//   master : environment side (timing controller, image memories, DAC)
interface vga_multi_window_painter_if #(
   parameter int N_WIN    = 2,
   parameter int IMG_W    = 256,
   parameter int IMG_H    = 256,
   parameter int PIX_BITS = 8
);
   localparam int AW = $clog2(IMG_W*IMG_H);
   localparam int HW = (N_WIN > 1) ? $clog2(N_WIN) : 1;

   logic [9:0]                i_x;
   logic [9:0]                i_y;
   logic                      i_video_on;
   logic                      i_hsync;
   logic                      i_vsync;
   logic                      i_mode;
   logic [HW-1:0]             i_highlight;
   logic                      i_hl_en;
   logic [AW-1:0]             o_rd_addr;
   logic [N_WIN*PIX_BITS-1:0] i_rd_data;
   logic [7:0]                o_red;
   logic [7:0]                o_green;
   logic [7:0]                o_blue;
   logic                      o_hsync;
   logic                      o_vsync;

   modport slave (
      input  i_x, i_y, i_video_on, i_hsync, i_vsync, i_mode, i_highlight, i_hl_en, i_rd_data,
      output o_rd_addr, o_red, o_green, o_blue, o_hsync, o_vsync
   );

   modport master (
      output i_x, i_y, i_video_on, i_hsync, i_vsync, i_mode, i_highlight, i_hl_en, i_rd_data,
      input  o_rd_addr, o_red, o_green, o_blue, o_hsync, o_vsync
   );
endinterface

// File: rtl/vga_multi_window_painter.sv
// Pipelined VGA painter: N_WIN image windows side by side, one shared memory
// read address, per-window pixel select, grayscale / 3-bit palette mapping,
// optional 1-pixel border on one window, sync delayed to match (MEM_LAT+2).
// Ports:
//   i_clk   pixel clock
//   i_rst_n asynchronous active-low reset
//   bus     painter bus (slave side), see vga_multi_window_painter_if
module vga_multi_window_painter #(
   parameter int          N_WIN      = 2,
   parameter int          IMG_W      = 256,
   parameter int          IMG_H      = 256,
   parameter int          PIX_BITS   = 8,
   parameter int          ORIGIN_X   = 125,
   parameter int          ORIGIN_Y   = 150,
   parameter int          GAP        = 0,
   parameter int          MEM_LAT    = 1,
   parameter logic [23:0] BG_RGB     = 24'h0C1990,
   parameter logic [23:0] BORDER_RGB = 24'hFF0000
) (
   input logic                      i_clk,
   input logic                      i_rst_n,
   vga_multi_window_painter_if.slave bus
);
   localparam int AW = $clog2(IMG_W*IMG_H);
   localparam int HW = (N_WIN > 1) ? $clog2(N_WIN) : 1;
   // Coordinates widened so window bounds past column 1023 never wrap.
   localparam int CW = 14;
   typedef logic [CW-1:0] crd_t;

   typedef struct packed {
      logic          hit;
      logic [HW-1:0] idx;
      logic          border;
      logic          vid;
      logic          hs;
      logic          vs;
   } pipe_t;
   localparam pipe_t PIPE_RST = '{hit: 1'b0, idx: '0, border: 1'b0, vid: 1'b0, hs: 1'b1, vs: 1'b1};

   function automatic crd_t left_col(input int k);
      return crd_t'(ORIGIN_X + k*(IMG_W+GAP));
   endfunction

   function automatic logic [23:0] pal(input logic [2:0] p);
      case (p)
         3'd0:    return 24'h000000;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FF00;
         3'd3:    return 24'hFFFFFF;
         3'd4:    return 24'h000050;
         3'd5:    return 24'h005050;
         3'd6:    return 24'h500050;
         default: return 24'h505050;
      endcase
   endfunction

   // Shadowed controls, updated only on the vsync falling edge.
   logic          r_vs_prev, r_mode, r_hl_en;
   logic [HW-1:0] r_hl;
   logic [AW-1:0] r_addr;
   pipe_t         r_pipe [0:MEM_LAT];   // [0] = stage 0, [1..MEM_LAT] = delay line
   logic [23:0]   r_rgb;
   logic          r_hs, r_vs;

   // ---------------- stage 0: window hit / address ----------------
   crd_t          w_x, w_y, w_left, w_row, w_col;
   logic          w_in_y, w_hit, w_edge, w_border;
   logic [N_WIN-1:0] w_in_x;
   logic [HW-1:0] w_idx;
   logic [AW-1:0] w_addr;

   assign w_x    = crd_t'(bus.i_x);
   assign w_y    = crd_t'(bus.i_y);
   assign w_in_y = (w_y >= crd_t'(ORIGIN_Y)) && (w_y < crd_t'(ORIGIN_Y + IMG_H));

   for (genvar k = 0; k < N_WIN; k++) begin : g_win
      assign w_in_x[k] = (w_x >= left_col(k)) && (w_x < left_col(k) + crd_t'(IMG_W));
   end

   // Windows never overlap, so at most one w_in_x bit is set.
   always_comb begin
      w_idx  = '0;
      w_left = '0;
      for (int k = N_WIN-1; k >= 0; k--) begin
         if (w_in_x[k]) begin
            w_idx  = HW'(k);
            w_left = left_col(k);
         end
      end
      w_hit    = bus.i_video_on && w_in_y && (|w_in_x);
      w_row    = w_y - crd_t'(ORIGIN_Y);
      w_col    = w_x - w_left;
      w_addr   = AW'(32'(w_row)*32'(IMG_W) + 32'(w_col));
      w_edge   = (w_x == w_left) || (w_x == w_left + crd_t'(IMG_W-1)) ||
                 (w_y == crd_t'(ORIGIN_Y)) || (w_y == crd_t'(ORIGIN_Y + IMG_H - 1));
      // A highlight index >= N_WIN never equals w_idx, so no border is drawn.
      w_border = w_hit && (w_idx == r_hl) && w_edge;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vs_prev <= 1'b1;
         r_mode    <= 1'b0;
         r_hl      <= '0;
         r_hl_en   <= 1'b0;
         r_addr    <= '0;
         for (int i = 0; i <= MEM_LAT; i++) r_pipe[i] <= PIPE_RST;
      end else begin
         r_vs_prev <= bus.i_vsync;
         if (r_vs_prev && !bus.i_vsync) begin
            r_mode  <= bus.i_mode;
            r_hl    <= bus.i_highlight;
            r_hl_en <= bus.i_hl_en;
         end
         if (w_hit) r_addr <= w_addr;
         r_pipe[0] <= '{hit: w_hit, idx: w_idx, border: w_border,
                        vid: bus.i_video_on, hs: bus.i_hsync, vs: bus.i_vsync};
         for (int i = 1; i <= MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   // ---------------- final stage: colour ----------------
   pipe_t                 w_q;
   logic [PIX_BITS-1:0]   w_pix;
   logic [PIX_BITS+2:0]   w_pix_ext;
   logic [7:0]            w_gray;
   logic [23:0]           w_rgb;

   assign w_q       = r_pipe[MEM_LAT];
   assign w_pix_ext = {3'b000, w_pix};

   always_comb begin
      w_pix = '0;
      for (int k = 0; k < N_WIN; k++)
         if (w_q.idx == HW'(k)) w_pix = bus.i_rd_data[k*PIX_BITS +: PIX_BITS];
   end

   // Left-align the pixel to 8 bits.
   if (PIX_BITS >= 8) begin : g_gray_trunc
      assign w_gray = w_pix[PIX_BITS-1 -: 8];
   end else begin : g_gray_fill
      assign w_gray = {w_pix, {(8-PIX_BITS){1'b0}}};
   end

   always_comb begin
      w_rgb = BG_RGB;
      if (!w_q.vid)                    w_rgb = 24'h000000;
      else if (w_q.border && r_hl_en)  w_rgb = BORDER_RGB;
      else if (w_q.hit)                w_rgb = r_mode ? pal(w_pix_ext[2:0]) : {3{w_gray}};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rgb <= '0;
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
      end else begin
         r_rgb <= w_rgb;
         r_hs  <= w_q.hs;
         r_vs  <= w_q.vs;
      end
   end

   assign bus.o_rd_addr = r_addr;
   assign bus.o_red     = r_rgb[23:16];
   assign bus.o_green   = r_rgb[15:8];
   assign bus.o_blue    = r_rgb[7:0];
   assign bus.o_hsync   = r_hs;
   assign bus.o_vsync   = r_vs;
endmodule

// File: tb/tb_vga_multi_window_painter.sv
// Bench for vga_multi_window_painter: three windows, synchronous image memories
// modelled as arrays, every output cycle compared against a per-pixel model.
module tb_vga_multi_window_painter;
   localparam int N_WIN = 3, IMG_W = 256, IMG_H = 256, PIX_BITS = 8;
   localparam int OX = 125, OY = 150, GAP = 0, MEM_LAT = 1, LAT = MEM_LAT + 2;
   localparam logic [23:0] BG = 24'h0C1990, BORD = 24'hFF0000;
   localparam int NC = 8192;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   vga_multi_window_painter_if #(.N_WIN(N_WIN), .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_BITS(PIX_BITS)) bus ();

   vga_multi_window_painter #(
      .N_WIN(N_WIN), .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_BITS(PIX_BITS),
      .ORIGIN_X(OX), .ORIGIN_Y(OY), .GAP(GAP), .MEM_LAT(MEM_LAT),
      .BG_RGB(BG), .BORDER_RGB(BORD)
   ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:N_WIN-1][0:IMG_W*IMG_H-1];

   // One-cycle synchronous read per window.
   always @(posedge clk)
      for (int k = 0; k < N_WIN; k++) bus.i_rd_data[k*PIX_BITS +: PIX_BITS] <= mem[k][bus.o_rd_addr];

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Per-pixel history (indexed by the clock edge that samples the pixel).
   bit       h_vid [NC], h_hit [NC], h_bord [NC], h_hs [NC], h_vs [NC];
   bit [7:0] h_pix [NC];
   bit       s_mode [NC], s_en [NC];   // shadow state in force at that edge
   int       cyc;
   bit       sh_mode, sh_en, prev_vs;
   int       sh_hl;
   int       exp_addr;

   function automatic logic [23:0] pal(input logic [2:0] p);
      logic [23:0] t [8] = '{24'h000000, 24'hFFFF00, 24'h00FF00, 24'hFFFFFF,
                             24'h000050, 24'h005050, 24'h500050, 24'h505050};
      return t[p];
   endfunction

   function automatic logic [23:0] expect_rgb(input int n, input int m);
      if (!h_vid[n])                return 24'h000000;
      if (h_bord[n] && s_en[m])     return BORD;
      if (h_hit[n])                 return s_mode[m] ? pal(h_pix[n][2:0]) : {3{h_pix[n]}};
      return BG;
   endfunction

   task automatic fake_entry(input int n);
      h_vid[n] = 0; h_hit[n] = 0; h_bord[n] = 0; h_hs[n] = 1; h_vs[n] = 1; h_pix[n] = 0;
   endtask

   // Drive one pixel at the negedge, advance one clock, check at the next negedge.
   task automatic step(input int x, input int y, input bit vid, input bit hs, input bit vs,
                       input bit mode, input int hl, input bit en);
      bit hit; int k, col, row, n;
      bus.i_x = 10'(x); bus.i_y = 10'(y); bus.i_video_on = vid;
      bus.i_hsync = hs; bus.i_vsync = vs; bus.i_mode = mode;
      bus.i_highlight = 2'(hl); bus.i_hl_en = en;
      hit = 0; k = 0;
      if (vid && y >= OY && y < OY + IMG_H)
         for (int w = 0; w < N_WIN; w++)
            if (x >= OX + w*(IMG_W+GAP) && x < OX + w*(IMG_W+GAP) + IMG_W) begin hit = 1; k = w; end
      col = x - (OX + k*(IMG_W+GAP));
      row = y - OY;
      h_vid[cyc] = vid; h_hit[cyc] = hit; h_hs[cyc] = hs; h_vs[cyc] = vs;
      h_pix[cyc] = hit ? mem[k][row*IMG_W + col] : 8'h00;
      h_bord[cyc] = hit && (k == sh_hl) && (col == 0 || col == IMG_W-1 || row == 0 || row == IMG_H-1);
      s_mode[cyc] = sh_mode; s_en[cyc] = sh_en;
      if (prev_vs && !vs) begin sh_mode = mode; sh_hl = hl; sh_en = en; end
      prev_vs = vs;
      if (hit) exp_addr = row*IMG_W + col;
      @(posedge clk); @(negedge clk);
      n = cyc - (LAT - 1);
      chk("rd_addr", 32'(bus.o_rd_addr), 32'(exp_addr));
      chk("rgb", {8'h00, bus.o_red, bus.o_green, bus.o_blue}, {8'h00, expect_rgb(n, cyc)});
      chk("hsync", 32'(bus.o_hsync), 32'(h_hs[n]));
      chk("vsync", 32'(bus.o_vsync), 32'(h_vs[n]));
      cyc++;
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) step(0, 0, 0, 1, 1, 0, 0, 0);
   endtask

   // Load shadow controls through a vsync falling edge.
   task automatic vfall(input bit mode, input int hl, input bit en);
      step(0, 0, 0, 1, 1, mode, hl, en);
      step(0, 0, 0, 1, 0, mode, hl, en);
      step(0, 0, 0, 1, 1, mode, hl, en);
   endtask

   task automatic model_reset();
      sh_mode = 0; sh_en = 0; sh_hl = 0; prev_vs = 1; exp_addr = 0;
      fake_entry(cyc - 1); fake_entry(cyc - 2);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_addr"}, 32'(bus.o_rd_addr), 32'd0);
      chk({tag, "_rgb"}, {8'h00, bus.o_red, bus.o_green, bus.o_blue}, 32'd0);
      chk({tag, "_hs"}, 32'(bus.o_hsync), 32'd1);
      chk({tag, "_vs"}, 32'(bus.o_vsync), 32'd1);
   endtask

   initial begin
      bit hs, vs, md, en; int hl, x, y;
      for (int k = 0; k < N_WIN; k++)
         for (int a = 0; a < IMG_W*IMG_H; a++) mem[k][a] = 8'($urandom);
      mem[0][0]   = 8'hA0;
      mem[1][256] = 8'h03;
      bus.i_x = '0; bus.i_y = '0; bus.i_video_on = 0; bus.i_hsync = 1; bus.i_vsync = 1;
      bus.i_mode = 0; bus.i_highlight = '0; bus.i_hl_en = 0;

      #1 rst_n = 1'b0;
      #1 check_reset_vals("reset");
      @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      cyc = 2;
      model_reset();

      // Window 0 origin, grayscale.
      step(125, 150, 1, 1, 1, 0, 0, 0);
      idle(3);
      // Window 1, palette mode.
      vfall(1, 0, 0);
      step(381, 151, 1, 1, 1, 1, 0, 0);
      idle(3);
      // Outside windows and blanking.
      step(124, 150, 1, 1, 1, 1, 0, 0);
      step(637, 406, 1, 1, 1, 1, 0, 0);
      step(300, 200, 0, 1, 1, 1, 0, 0);
      idle(3);
      // Border on window 1, then an out-of-range highlight.
      vfall(1, 1, 1);
      step(381, 200, 1, 1, 1, 1, 1, 1);
      step(382, 200, 1, 1, 1, 1, 1, 1);
      step(500, 150, 1, 1, 1, 1, 1, 1);
      step(636, 405, 1, 1, 1, 1, 1, 1);
      vfall(1, 3, 1);
      step(381, 200, 1, 1, 1, 1, 3, 1);
      step(636, 150, 1, 1, 1, 1, 3, 1);
      idle(3);
      // Mode toggled mid-frame: palette stays until the next vsync fall.
      for (int i = 0; i < 6; i++) step(130 + i, 160, 1, 1, 1, 0, 3, 0);
      vfall(0, 3, 0);
      for (int i = 0; i < 6; i++) step(130 + i, 160, 1, 1, 1, 1, 3, 0);
      // Window boundaries, with border on window 2.
      vfall(0, 2, 1);
      for (int w = 0; w < N_WIN; w++) begin
         int l = OX + w*(IMG_W+GAP);
         int xs [4] = '{l - 1, l, l + IMG_W - 1, l + IMG_W};
         int ys [4] = '{OY - 1, OY, OY + IMG_H - 1, OY + IMG_H};
         foreach (xs[i]) foreach (ys[j]) step(xs[i] & 1023, ys[j], 1, 1, 1, 0, 2, 1);
      end
      // hsync pulse.
      for (int i = 0; i < 8; i++) step(200 + i, 300, 1, (i < 2 || i > 4), 1, 0, 2, 1);
      idle(3);
      // Reset asserted mid-line.
      step(400, 300, 1, 1, 1, 0, 2, 1);
      step(401, 300, 1, 0, 1, 0, 2, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      bus.i_vsync = 1;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) step(402 + i, 300, 1, 1, 1, 0, 0, 0);

      // Randomised frame traffic.
      hs = 1; vs = 1;
      for (int i = 0; i < 3000; i++) begin
         x  = $urandom_range(0, 1023);
         y  = $urandom_range(100, 460);
         if ($urandom_range(0, 39) == 0) hs = ~hs;
         if ($urandom_range(0, 99) == 0) vs = ~vs;
         md = 1'($urandom);
         en = ($urandom_range(0, 3) != 0);
         hl = $urandom_range(0, 3);
         step(x, y, ($urandom_range(0, 7) != 0), hs, vs, md, hl, en);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_multi_window_painter.md
Name: vga_multi_window_painter

Overview:
- Pipelined VGA pixel painter for the histogram-equalisation display path.
- Places N_WIN image windows side by side on screen, for example original and equalised images, and generates one shared read address for the image memories.
- Selects the returned pixel of the hit window, maps it through grayscale or 3-bit palette mode, and outputs registered RGB with sync delayed to match.
- Sits between the VGA timing controller and the DAC/RGB pins.

Parameters:
- N_WIN, 2, number of windows and image memories (1..4)
- IMG_W, 256, window width in pixels
- IMG_H, 256, window height in pixels
- PIX_BITS, 8, bits per memory pixel
- ORIGIN_X, 125, left column of window 0
- ORIGIN_Y, 150, top row of all windows
- GAP, 0, blank columns between adjacent windows
- MEM_LAT, 1, memory read latency in cycles (1..3)
- BG_RGB, 24'h0C1990, background colour {R,G,B}
- BORDER_RGB, 24'hFF0000, highlight border colour

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-low reset
- X  in  10  current column from timing controller
- Y  in  10  current row from timing controller
- video_on  in  1  active-video flag
- hsync_in  in  1  horizontal sync from timing controller
- vsync_in  in  1  vertical sync from timing controller
- mode  in  1  0 = grayscale (pixel MSBs to R, G and B), 1 = 3-bit palette on pixel[2:0]
- highlight  in  clog2(N_WIN)  window that receives a 1-pixel border
- hl_en  in  1  border enable
- rd_addr  out  clog2(IMG_W*IMG_H)  shared memory read address
- rd_data  in  N_WIN*PIX_BITS  concatenated memory outputs; window k occupies bits [k*PIX_BITS +: PIX_BITS]
- Red  out  8  red output
- Green  out  8  green output
- Blue  out  8  blue output
- hsync_out  out  1  hsync delayed by LAT
- vsync_out  out  1  vsync delayed by LAT

Behaviour:
- Reset (rst low, asynchronous): rd_addr=0, Red/Green/Blue=0, hsync_out=vsync_out=1, all pipeline valid and index registers cleared, shadow mode/highlight/hl_en=0.
- Total latency LAT = MEM_LAT+2 cycles from X/Y to RGB and sync outputs.
- Stage 0, registered:
  - Window k spans X in [ORIGIN_X+k*(IMG_W+GAP), ORIGIN_X+k*(IMG_W+GAP)+IMG_W) and Y in [ORIGIN_Y, ORIGIN_Y+IMG_H). Bounds are half-open and use full 10-bit compares, no truncation.
  - On a hit: rd_addr = (Y-ORIGIN_Y)*IMG_W + (X-window left column), and win_idx = k.
  - hit requires video_on=1. On a miss, rd_addr holds its previous value.
  - Border flag is set when the pixel lies on the first or last row or column of the highlighted window.
- Delay line: hit, win_idx, border, video_on, hsync_in and vsync_in travel through a MEM_LAT-deep shift register alongside the memory access.
- Stage final, registered, priority order:
  1. !video_on gives RGB=0.
  2. border && hl_en gives BORDER_RGB.
  3. hit gives the colour of the selected pixel under the shadowed mode.
  4. Otherwise BG_RGB.
- Grayscale mode: R=G=B=pixel left-aligned to 8 bits. If PIX_BITS<8, zero-fill the LSBs; if PIX_BITS>8, take the top 8 bits.
- Palette mode (pixel[2:0]):
  - 0: 000000
  - 1: FFFF00
  - 2: 00FF00
  - 3: FFFFFF
  - 4: 000050
  - 5: 005050
  - 6: 500050
  - 7: 505050
- Shadow registers: mode, highlight and hl_en are sampled only on the falling edge of vsync_in, detected with a registered previous value. Changes mid-frame must not tear the image.
- highlight >= N_WIN means no border is drawn.
- Windows do not overlap for any GAP >= 0. Windows that extend past X=1023 are clipped: compare with 11-bit sums.
- Reset asserted mid-frame clears the pipeline. After release, the first LAT output cycles show background or black with sync held at 1 until real data propagates.

Test Plan:
- X=125,Y=150,video_on=1, mode=0, rd_data window0=8'hA0 → after 3 cycles (MEM_LAT=1) rd_addr=0 and RGB=A0A0A0.
- X=381,Y=151, N_WIN=2,GAP=0 → rd_addr=256, window 1 selected; window1 data 8'h03 with mode=1 → RGB=FFFFFF.
- X=124,Y=150 and X=637,Y=406 → outside all windows → RGB=0C1990; video_on=0 → RGB=000000.
- hl_en=1, highlight=1: X=381,Y=200 → FF0000; X=382,Y=200 → pixel colour; highlight=2 → no border anywhere.
- Toggle mode mid-frame → output colour unchanged until the next vsync falling edge, then it switches.
- hsync_in pulse → hsync_out is the same pulse delayed LAT cycles; rst low mid-line → all outputs at reset values immediately, without waiting for a clock edge.
